// File: rtl/store_lane_buffer_if.sv
// store_lane_buffer_if: M-stage store/load request and data-memory drain signals
interface store_lane_buffer_if;
    logic        st_valid;
    logic [3:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_exc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    modport master (
        output st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        input  st_ready, st_exc, ld_hit, mem_req, mem_addr, mem_wdata, mem_be
    );
    modport slave (
        input  st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        output st_ready, st_exc, ld_hit, mem_req, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_lane_buffer.sv
// store_lane_buffer: lane-encodes SW/SH/SB stores into a 2-entry FIFO drained over req/ack
module store_lane_buffer (
    input logic clk,
    input logic reset_n,
    store_lane_buffer_if.slave bus
);
    logic [1:0]  cnt;
    logic        wr_ptr, rd_ptr;
    logic [29:0] addr_q [2];
    logic [31:0] data_q [2];
    logic [3:0]  be_q [2];
    logic [1:0]  a;
    logic        is_sw, is_sh, is_sb, legal, mis, push, pop, v0, v1;
    logic [3:0]  enc_be;
    logic [31:0] enc_data;
    logic        unused_ld_lsb;
    assign unused_ld_lsb = &{1'b0, bus.ld_addr[1:0]};
    always_comb begin
        a        = bus.st_addr[1:0];
        is_sw    = bus.st_type == 4'b0000;
        is_sb    = bus.st_type == 4'b0001;
        is_sh    = bus.st_type == 4'b0010;
        legal    = is_sw | is_sb | is_sh;
        mis      = (is_sw & (a != 2'b00)) | (is_sh & a[0]);
        enc_be   = is_sw ? 4'hf : is_sh ? (a[1] ? 4'hc : 4'h3) : 4'b0001 << a;
        enc_data = is_sw ? bus.st_data : is_sh ? {2{bus.st_data[15:0]}} : {4{bus.st_data[7:0]}};
        push     = bus.st_valid & bus.st_ready & legal & !mis;
        pop      = bus.mem_req & bus.mem_ack;
        // slot validity comes from count/rd_ptr so stale slots never match
        v0       = (cnt == 2'd2) | ((cnt == 2'd1) & !rd_ptr);
        v1       = (cnt == 2'd2) | ((cnt == 2'd1) & rd_ptr);
    end
    assign bus.st_exc    = bus.st_valid & legal & mis;
    assign bus.st_ready  = cnt != 2'd2;
    assign bus.mem_req   = cnt != 2'd0;
    assign bus.mem_addr  = {addr_q[rd_ptr], 2'b00};
    assign bus.mem_wdata = data_q[rd_ptr];
    assign bus.mem_be    = be_q[rd_ptr];
    assign bus.ld_hit    = bus.ld_valid & ((v0 & (addr_q[0] == bus.ld_addr[31:2])) |
                                           (v1 & (addr_q[1] == bus.ld_addr[31:2])));
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= bus.st_addr[31:2];
                data_q[wr_ptr] <= enc_data;
                be_q[wr_ptr]   <= enc_be;
                wr_ptr         <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_store_lane_buffer.sv
// tb_store_lane_buffer: table-driven lane/misalignment vectors plus FIFO corner sequences
module tb_store_lane_buffer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    store_lane_buffer_if bus ();
    store_lane_buffer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0]  ty;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exc;
        logic        push;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } vec_t;
    vec_t v [10];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive_st(input logic [3:0] ty, input logic [31:0] addr, input logic [31:0] data);
        bus.st_valid = 1'b1;
        bus.st_type  = ty;
        bus.st_addr  = addr;
        bus.st_data  = data;
    endtask
    task automatic push_one(input logic [31:0] addr);
        @(posedge clk); #1;
        drive_st(4'b0000, addr, addr ^ 32'hA5A5_0000);
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
    endtask
    initial begin
        v[0] = '{4'b0001, 32'h0000_1003, 32'h1234_56AB, 1'b0, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
        v[1] = '{4'b0010, 32'h0000_2002, 32'hFFFF_BEEF, 1'b0, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF};
        v[2] = '{4'b0000, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF};
        v[3] = '{4'b0000, 32'h0000_0002, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 4'b0, 32'h0};
        v[4] = '{4'b0010, 32'h0000_0001, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 4'b0, 32'h0};
        v[5] = '{4'b0001, 32'h0000_0001, 32'h0000_00CD, 1'b0, 1'b1, 32'h0000_0000, 4'b0010, 32'hCDCD_CDCD};
        v[6] = '{4'b0010, 32'h0000_0010, 32'h9999_1234, 1'b0, 1'b1, 32'h0000_0010, 4'b0011, 32'h1234_1234};
        v[7] = '{4'b0001, 32'h0000_0022, 32'h0000_0077, 1'b0, 1'b1, 32'h0000_0020, 4'b0100, 32'h7777_7777};
        v[8] = '{4'b0011, 32'h0000_0040, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0};
        v[9] = '{4'b0000, 32'h0000_0003, 32'h4444_4444, 1'b1, 1'b0, 32'h0, 4'b0, 32'h0};
        bus.st_valid = 1'b0; bus.st_type = 4'b0000; bus.st_addr = 32'h2; bus.st_data = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
        chk("idle_st_exc", 32'(bus.st_exc), 32'd0);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive_st(v[i].ty, v[i].addr, v[i].data);
            #1;
            chk($sformatf("v%0d_exc", i), 32'(bus.st_exc), 32'(v[i].exc));
            @(posedge clk); #1;
            bus.st_valid = 1'b0;
            chk($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(v[i].push));
            if (v[i].push) begin
                chk($sformatf("v%0d_addr", i), bus.mem_addr, v[i].maddr);
                chk($sformatf("v%0d_be", i), 32'(bus.mem_be), 32'(v[i].be));
                chk($sformatf("v%0d_wdata", i), bus.mem_wdata, v[i].wdata);
            end
        end
        @(posedge clk); #1;
        chk("vec_drained", 32'(bus.mem_req), 32'd0);
        // backpressure: two entries fill the FIFO, third waits for a pop
        bus.mem_ack = 1'b0;
        push_one(32'h10);
        push_one(32'h14);
        chk("bp_full_ready", 32'(bus.st_ready), 32'd0);
        drive_st(4'b0000, 32'h18, 32'h0000_0018);
        @(posedge clk); #1;
        chk("bp_third_held_ready", 32'(bus.st_ready), 32'd0);
        chk("bp_head_stable", bus.mem_addr, 32'h10);
        bus.mem_ack = 1'b1;
        #1;
        chk("bp_ready_during_ack", 32'(bus.st_ready), 32'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("bp_ready_after_pop", 32'(bus.st_ready), 32'd1);
        chk("bp_head2", bus.mem_addr, 32'h14);
        @(posedge clk); #1;
        bus.st_valid = 1'b0;
        chk("bp_third_accepted", 32'(bus.st_ready), 32'd0);
        chk("bp_head2_hold", bus.mem_addr, 32'h14);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("bp_head3", bus.mem_addr, 32'h18);
        chk("bp_head3_data", bus.mem_wdata, 32'h0000_0018);
        @(posedge clk); #1;
        chk("bp_empty", 32'(bus.mem_req), 32'd0);
        // load hazard against a pending word
        bus.mem_ack = 1'b0;
        push_one(32'h0000_4004);
        bus.ld_valid = 1'b1;
        bus.ld_addr = 32'h0000_4006;
        #1 chk("ld_same_word", 32'(bus.ld_hit), 32'd1);
        bus.ld_addr = 32'h0000_4008;
        #1 chk("ld_next_word", 32'(bus.ld_hit), 32'd0);
        bus.ld_valid = 1'b0;
        bus.ld_addr = 32'h0000_4006;
        #1 chk("ld_not_valid", 32'(bus.ld_hit), 32'd0);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        bus.ld_valid = 1'b1;
        #1 chk("ld_after_pop", 32'(bus.ld_hit), 32'd0);
        bus.ld_valid = 1'b0;
        // asynchronous reset while two entries wait
        push_one(32'h50);
        push_one(32'h54);
        chk("rd_two_pending", 32'(bus.st_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("rd_req_drop", 32'(bus.mem_req), 32'd0);
        chk("rd_ready", 32'(bus.st_ready), 32'd1);
        chk("rd_addr_clr", bus.mem_addr, 32'd0);
        #1 reset_n = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr = 32'h50;
        @(posedge clk); #1;
        chk("rd_no_stale_req", 32'(bus.mem_req), 32'd0);
        chk("rd_no_stale_hit", 32'(bus.ld_hit), 32'd0);
        bus.ld_valid = 1'b0;
        push_one(32'h60);
        chk("rd_new_push", bus.mem_addr, 32'h60);
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("rd_final_empty", 32'(bus.mem_req), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_lane_buffer.md
# store_lane_buffer

Store-side partner of the load extender in the P7 pipeline. It sits between the M stage and the data-memory/bridge port. It converts SW/SH/SB requests into a word-aligned address, a 4-bit byte enable and lane-replicated write data. Accepted stores are held in a 2-entry FIFO and drained to memory over a req/ack handshake. It flags misaligned stores (AdES) and reports load-after-pending-store hazards so the pipeline can stall.

## Interface
- DEPTH, 2, FIFO entries. Fixed at 2; pointers are 1 bit and the count is 2 bits.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- st_valid  in  1  M-stage store request
- st_type  in  4  0000 SW, 0001 SB, 0010 SH; any other value is treated as no store
- st_addr  in  32  byte address from the ALU
- st_data  in  32  rt value
- st_ready  out  1  FIFO can accept a store
- st_exc  out  1  misaligned store (AdES), combinational
- ld_valid  in  1  M-stage load present
- ld_addr  in  32  load byte address
- ld_hit  out  1  a pending entry targets the same word
- mem_req  out  1  head entry valid
- mem_addr  out  32  head word address, bits [1:0] = 00
- mem_wdata  out  32  head write data
- mem_be  out  4  head byte enables
- mem_ack  in  1  memory accepted the head entry this cycle

## Operation
- Lane encoding, computed from a = st_addr[1:0]:
  - SW: be = 1111, data = st_data.
  - SH: be = 0011 when a[1] = 0, else 1100; data = {2{st_data[15:0]}}.
  - SB: be = 0001 << a; data = {4{st_data[7:0]}}.
  - Stored address = {st_addr[31:2], 2'b00}.
- Misalignment:
  - Condition: SW with a != 00, or SH with a[0] = 1. SB is never misaligned.
  - st_exc = st_valid & legal type & misaligned. This is combinational and independent of st_ready.
  - A misaligned store is never enqueued.
- Push: at a clock edge where st_valid & st_ready & legal type & !misaligned. The encoded entry is written at wr_ptr, then wr_ptr toggles.
- Pop: at a clock edge where mem_req & mem_ack. rd_ptr toggles.
- The count is updated by +1, -1 or 0. A simultaneous push and pop leaves the count unchanged.
- st_ready = (count != 2). It depends only on registered state; there is no full-bypass on pop.
- mem_req = (count != 0). mem_addr, mem_wdata and mem_be come directly from the entry registers at rd_ptr.
- mem_ack while mem_req = 0 is ignored: no pointer or count change.
- ld_hit = ld_valid & OR over valid entries of (entry_addr[31:2] == ld_addr[31:2]). This is a word-granular, conservative check. Valid entries are identified by count and rd_ptr, never by stale slots.
- Reset (async, reset_n low): count, wr_ptr, rd_ptr and all entry address/data/be registers go to 0. Consequently mem_req = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, st_ready = 1 and ld_hit = 0. st_exc still follows its inputs but must read 0 whenever st_valid = 0.
- Reset asserted mid-drain discards all pending entries. No further mem_req is issued until a new push.

## Timing
- Latency: a store accepted at edge N drives mem_req = 1 with its fields during cycle N+1. This holds when the FIFO was empty before the push.
- Handshake: mem_req, mem_addr, mem_wdata and mem_be hold stable until the cycle in which mem_ack = 1. The next entry is presented in the following cycle.
- Throughput: with mem_ack tied to 1, one store per cycle is sustained. A push and a pop in the same cycle are both honoured.
- When full (count = 2), st_ready = 0 even if mem_ack = 1 in that cycle. A new store is accepted one cycle after the pop.
- ld_hit reflects registered FIFO contents only. A store being pushed in the same cycle is not included.
- A single store passes through at most 2 register stages (entry register to memory port).

## Test plan
- Reset then idle: reset_n = 0 for 2 cycles, then 1. Required: mem_req = 0, mem_be = 0, st_ready = 1, ld_hit = 0, st_exc = 0.
- Lane encoding, with mem_ack = 1:
  - SB addr 0x0000_1003, data 0x1234_56AB → next cycle mem_addr = 0x0000_1000, mem_be = 1000, mem_wdata = 0xABAB_ABAB.
  - SH addr 0x0000_2002, data 0xFFFF_BEEF → mem_be = 1100, mem_wdata = 0xBEEF_BEEF.
  - SW addr 0x0000_3000, data 0xDEAD_BEEF → mem_be = 1111, mem_wdata = 0xDEAD_BEEF.
- Misalignment:
  - SW addr 0x0000_0002 → st_exc = 1 in the same cycle, count unchanged, mem_req stays 0.
  - SH addr 0x0000_0001 → st_exc = 1.
  - SB addr 0x0000_0001 → st_exc = 0 and the store is enqueued.
- Backpressure: mem_ack = 0, push SW 0x10 and SW 0x14.
  - Required: st_ready = 0, and a third store at 0x18 is not accepted.
  - Raise mem_ack for one cycle: head 0x10 pops, st_ready = 1 the next cycle, and 0x18 is then accepted behind 0x14.
  - Final drain order is 0x10, 0x14, 0x18.
- Load hazard: with SW 0x0000_4004 pending and mem_ack = 0, drive ld_valid = 1.
  - ld_addr = 0x0000_4006 → ld_hit = 1.
  - ld_addr = 0x0000_4008 → ld_hit = 0.
  - After the entry pops, ld_addr = 0x0000_4006 → ld_hit = 0.
- Reset mid-drain: with 2 entries pending and mem_ack = 0, pulse reset_n low asynchronously between edges. Required: mem_req drops to 0 immediately and st_ready = 1. No stale entry reappears after reset_n returns high.
